// File: rtl/chroma_decimator_pkg.sv
// Shared constants and state encoding for the 2:1 horizontal chroma decimator.
package chroma_pkg;

    // Symmetric 5-tap low-pass coefficients (Q8) and the rounding offset.
    localparam int signed C_OUT = -16;
    localparam int signed C_MID = 72;
    localparam int signed C_CTR = 144;
    localparam int signed RND   = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC0,
        MAC1,
        MAC2,
        EMIT
    } dec_state_t;

endpackage

// File: rtl/chroma_decimator_mult.sv
// Unsigned 32x32 multiplier shared by all filter taps.
module Multiplier (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/chroma_decimator.sv
// 2:1 horizontal chroma decimator: 5-tap symmetric low-pass, one output per input pair,
// edge samples replicated at both ends of each row.
module chroma_decimator
    import chroma_pkg::*;
#(
    parameter int unsigned ROW_LEN = 320,
    parameter int unsigned ACC_W   = 20
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       en,
    input  logic       flush,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       row_done,
    output logic       busy
);

    localparam int unsigned N_OUT = ROW_LEN / 2;
    localparam int unsigned COL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_OUT - 1);

    // Coefficient magnitudes; the sign of the outer taps is applied when accumulating.
    localparam logic [31:0] K_OUT = 32'(-C_OUT);
    localparam logic [31:0] K_MID = 32'(C_MID);
    localparam logic [31:0] K_CTR = 32'(C_CTR);

    dec_state_t              state_q;
    logic [7:0]              w_q [5];
    logic [1:0]              need_q;
    logic [COL_W-1:0]        col_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [7:0]              out_data_q;
    logic                    out_valid_q;
    logic                    row_done_q;

    logic [8:0]              p0;
    logic [8:0]              p1;
    logic [31:0]             mul_a;
    logic [31:0]             mul_b;
    logic [63:0]             mul_p;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] shifted_d;
    logic [7:0]              clip_d;
    logic                    unused_hi;

    assign p0        = {1'b0, w_q[0]} + {1'b0, w_q[4]};
    assign p1        = {1'b0, w_q[1]} + {1'b0, w_q[3]};
    assign prod_s    = signed'(mul_p[ACC_W-1:0]);
    assign unused_hi = ^mul_p[63:ACC_W];

    assign in_ready  = (state_q == LOAD) && !flush;
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign row_done  = row_done_q;

    // Select the tap handled in the current MAC cycle for the shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MAC0: begin mul_a = K_OUT; mul_b = 32'(p0);     end
            MAC1: begin mul_a = K_MID; mul_b = 32'(p1);     end
            MAC2: begin mul_a = K_CTR; mul_b = 32'(w_q[2]); end
            default: ;
        endcase
    end

    Multiplier u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Final sum with rounding, arithmetic shift, then clip to 0..255.
    always_comb begin
        sum_d     = acc_q + prod_s + ACC_W'(RND);
        shifted_d = sum_d >>> 8;
        if (shifted_d[ACC_W-1])
            clip_d = '0;
        else if (|shifted_d[ACC_W-2:8])
            clip_d = '1;
        else
            clip_d = shifted_d[7:0];
    end

    // Row-sequencing FSM with window shift register, accumulator and registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            w_q         <= '{default: '0};
            need_q      <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            row_done_q  <= 1'b0;
        end else begin
            row_done_q <= 1'b0;
            if (flush) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (en) begin
                            state_q <= LOAD;
                            need_q  <= 2'd3;
                            col_q   <= '0;
                        end
                    end
                    LOAD: begin
                        if (in_valid) begin
                            if (need_q == 2'd3) begin
                                // Left edge: x0 fills the whole window so the
                                // next two shifts leave {x0,x0,x0,x1,x2}.
                                w_q <= '{default: in_data};
                            end else if (need_q == 2'd1 && col_q == COL_LAST) begin
                                // Right edge: shift twice in one step, replicating
                                // the last sample into w[4] without extra latency.
                                w_q[0] <= w_q[2];
                                w_q[1] <= w_q[3];
                                w_q[2] <= w_q[4];
                                w_q[3] <= in_data;
                                w_q[4] <= in_data;
                            end else begin
                                w_q[0] <= w_q[1];
                                w_q[1] <= w_q[2];
                                w_q[2] <= w_q[3];
                                w_q[3] <= w_q[4];
                                w_q[4] <= in_data;
                            end
                            need_q <= need_q - 2'd1;
                            if (need_q == 2'd1)
                                state_q <= MAC0;
                        end
                    end
                    MAC0: begin
                        acc_q   <= '0 - prod_s;
                        state_q <= MAC1;
                    end
                    MAC1: begin
                        acc_q   <= acc_q + prod_s;
                        state_q <= MAC2;
                    end
                    MAC2: begin
                        out_data_q  <= clip_d;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                    EMIT: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            if (col_q == COL_LAST) begin
                                row_done_q <= 1'b1;
                                col_q      <= '0;
                                need_q     <= 2'd3;
                                state_q    <= en ? LOAD : IDLE;
                            end else begin
                                col_q   <= col_q + COL_W'(1);
                                need_q  <= (col_q + COL_W'(1) == COL_LAST) ? 2'd1 : 2'd2;
                                state_q <= LOAD;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chroma_decimator.sv
// Self-checking bench for chroma_decimator with ROW_LEN=8 and a scoreboard of expected outputs.
module tb_chroma_decimator;

    localparam int N     = 8;
    localparam int N_OUT = N / 2;

    typedef int row_t [N];

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       en;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       row_done;
    logic       busy;

    int checks       = 0;
    int errors       = 0;
    int xfer_cnt     = 0;
    int row_done_cnt = 0;

    logic [7:0] sb [$];

    always #5 Clock = ~Clock;

    chroma_decimator #(.ROW_LEN(N), .ACC_W(20)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .en        (en),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_done  (row_done),
        .busy      (busy)
    );

    function automatic int sample_at(input row_t x, input int idx);
        int k;
        k = idx;
        if (k < 0) k = 0;
        if (k > N - 1) k = N - 1;
        return x[k];
    endfunction

    function automatic logic [7:0] model_out(input row_t x, input int j);
        int s;
        s = -16 * (sample_at(x, 2*j-2) + sample_at(x, 2*j+2))
            + 72 * (sample_at(x, 2*j-1) + sample_at(x, 2*j+1))
            + 144 * sample_at(x, 2*j) + 128;
        s = s >>> 8;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    // Output monitor: pop the scoreboard on every output transfer.
    always @(negedge Clock) begin
        logic [7:0] exp_v;
        if (Resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
            xfer_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %0d, required no output", out_data);
            end else begin
                exp_v = sb.pop_front();
                if (out_data !== exp_v) begin
                    errors++;
                    $display("FAIL out_data: got %0d, required %0d", out_data, exp_v);
                end
            end
        end
        if (Resetn === 1'b1 && row_done === 1'b1)
            row_done_cnt++;
    end

    task automatic push_row(input row_t x);
        for (int j = 0; j < N_OUT; j++)
            sb.push_back(model_out(x, j));
    endtask

    task automatic feed_row(input row_t x, input int n);
        for (int i = 0; i < n; i++) begin
            bit got;
            int cyc;
            in_data  = x[i][7:0];
            in_valid = 1'b1;
            got      = 1'b0;
            cyc      = 0;
            while (!got && cyc < 300) begin
                @(negedge Clock);
                got = (in_ready === 1'b1);
                @(posedge Clock);
                #1;
                cyc++;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL feed_timeout: sample %0d not accepted, in_ready=%b, required 1", i, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 500) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d outputs missing, required 0", tag, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge Clock);
        #1;
    endtask

    task automatic random_row(output row_t x);
        for (int i = 0; i < N; i++)
            x[i] = int'($urandom_range(0, 255));
    endtask

    task automatic test_reset;
        Resetn    = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        checks++; if (row_done !== 1'b0) begin errors++; $display("FAIL reset_row_done: got %b, required 0", row_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        Resetn = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_en_low_busy: got %b, required 0", busy); end
    endtask

    task automatic test_constant;
        row_t x;
        int   base;
        for (int i = 0; i < N; i++) x[i] = 100;
        en = 1'b1; out_ready = 1'b1;
        row_done_cnt = 0; base = xfer_cnt;
        for (int j = 0; j < N_OUT; j++) sb.push_back(8'd100);
        feed_row(x, N);
        wait_drain("constant");
        checks++; if (xfer_cnt - base !== N_OUT) begin errors++; $display("FAIL constant_count: got %0d, required %0d", xfer_cnt - base, N_OUT); end
        checks++; if (row_done_cnt !== 1) begin errors++; $display("FAIL constant_row_done: got %0d, required 1", row_done_cnt); end
    endtask

    task automatic test_row_start;
        row_t x;
        x = '{10, 20, 30, 40, 50, 60, 70, 80};
        sb.push_back(8'd12);
        for (int j = 1; j < N_OUT; j++) sb.push_back(model_out(x, j));
        feed_row(x, N);
        wait_drain("row_start");
    endtask

    task automatic test_clip;
        row_t a;
        row_t b;
        a = '{255, 0, 0, 0, 255, 0, 0, 0};
        b = '{0, 255, 255, 255, 0, 0, 0, 0};
        sb.push_back(model_out(a, 0));
        sb.push_back(8'd0);
        sb.push_back(model_out(a, 2));
        sb.push_back(model_out(a, 3));
        feed_row(a, N);
        wait_drain("clip_low");
        sb.push_back(model_out(b, 0));
        sb.push_back(8'd255);
        sb.push_back(model_out(b, 2));
        sb.push_back(model_out(b, 3));
        feed_row(b, N);
        wait_drain("clip_high");
    endtask

    task automatic test_backpressure;
        row_t x;
        int   base;
        random_row(x);
        push_row(x);
        base = xfer_cnt;
        out_ready = 1'b0;
        fork
            feed_row(x, N);
            begin
                logic [7:0] held;
                int cyc;
                cyc = 0;
                do begin
                    @(negedge Clock);
                    cyc++;
                end while (out_valid !== 1'b1 && cyc < 100);
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_wait_valid: out_valid=%b, required 1", out_valid);
                end
                held = out_data;
                for (int k = 0; k < 10; k++) begin
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: cycle %0d got %b, required 1", k, out_valid); end
                    checks++; if (out_data !== held) begin errors++; $display("FAIL stall_data: cycle %0d got %0d, required %0d", k, out_data, held); end
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b, required 0", k, in_ready); end
                    @(negedge Clock);
                end
                @(posedge Clock);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
        checks++; if (xfer_cnt - base !== N_OUT) begin errors++; $display("FAIL stall_count: got %0d, required %0d", xfer_cnt - base, N_OUT); end
    endtask

    task automatic test_ramp;
        row_t x;
        for (int i = 0; i < N; i++) x[i] = 10 * i;
        for (int j = 0; j < N_OUT - 1; j++) sb.push_back(model_out(x, j));
        sb.push_back(8'd61);
        feed_row(x, N);
        wait_drain("ramp");
    endtask

    task automatic test_back_to_back;
        row_t a;
        row_t b;
        int   base;
        random_row(a);
        random_row(b);
        push_row(a);
        push_row(b);
        row_done_cnt = 0; base = xfer_cnt;
        feed_row(a, N);
        feed_row(b, N);
        wait_drain("back_to_back");
        checks++; if (xfer_cnt - base !== 2 * N_OUT) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", xfer_cnt - base, 2 * N_OUT); end
        checks++; if (row_done_cnt !== 2) begin errors++; $display("FAIL b2b_row_done: got %0d, required 2", row_done_cnt); end
    endtask

    // Run a row until output col=2 is pending, leaving out_ready low.
    task automatic run_to_col2(input string tag);
        row_t x;
        int   base;
        random_row(x);
        push_row(x);
        base = xfer_cnt;
        out_ready = 1'b1;
        fork
            feed_row(x, 7);
            begin
                int cyc;
                cyc = 0;
                while (xfer_cnt < base + 2 && cyc < 200) begin
                    @(posedge Clock);
                    #1;
                    cyc++;
                end
                out_ready = 1'b0;
                cyc = 0;
                do begin
                    @(negedge Clock);
                    cyc++;
                end while (out_valid !== 1'b1 && cyc < 100);
            end
        join
        checks++;
        if (out_valid !== 1'b1 || xfer_cnt - base !== 2) begin
            errors++;
            $display("FAIL %s_pending: out_valid=%b transfers=%0d, required 1 and 2", tag, out_valid, xfer_cnt - base);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic full_row_after(input string tag);
        row_t x;
        int   base;
        random_row(x);
        push_row(x);
        row_done_cnt = 0; base = xfer_cnt;
        out_ready = 1'b1;
        feed_row(x, N);
        wait_drain(tag);
        checks++; if (xfer_cnt - base !== N_OUT) begin errors++; $display("FAIL %s_count: got %0d, required %0d", tag, xfer_cnt - base, N_OUT); end
        checks++; if (row_done_cnt !== 1) begin errors++; $display("FAIL %s_row_done: got %0d, required 1", tag, row_done_cnt); end
    endtask

    task automatic test_flush;
        run_to_col2("flush");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd55;
        @(negedge Clock);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
        @(posedge Clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b, required 0", busy); end
        sb.delete();
        full_row_after("after_flush");
    endtask

    task automatic test_reset_midrow;
        run_to_col2("reset");
        Resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL midreset_out_data: got %0d, required 0", out_data); end
        sb.delete();
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        full_row_after("after_reset");
    endtask

    task automatic test_en_low_midrow;
        row_t x;
        int   base;
        random_row(x);
        push_row(x);
        row_done_cnt = 0; base = xfer_cnt;
        out_ready = 1'b1;
        fork
            feed_row(x, N);
            begin
                repeat (6) @(posedge Clock);
                #1;
                en = 1'b0;
            end
        join
        wait_drain("en_low");
        checks++; if (xfer_cnt - base !== N_OUT) begin errors++; $display("FAIL en_low_count: got %0d, required %0d", xfer_cnt - base, N_OUT); end
        checks++; if (row_done_cnt !== 1) begin errors++; $display("FAIL en_low_row_done: got %0d, required 1", row_done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_low_idle: busy got %b, required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_row_start();
        test_clip();
        test_backpressure();
        test_ramp();
        test_back_to_back();
        test_flush();
        test_reset_midrow();
        test_en_low_midrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
